// File: rtl/serial_alu_if.sv
// serial_alu_if: start/operand request and result/status bundle for serial_alu.
interface serial_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    modport master(output start, op, a, b, input busy, done, result, zero, overflow);
    modport slave(input start, op, a, b, output busy, done, result, zero, overflow);
endinterface

// File: rtl/serial_alu.sv
// serial_alu: bit-serial AND/OR/ADD/SUB/SLT, one bit per clock LSB first; SLT resolved in one extra cycle.
// Define SERIAL_ALU_OVF_EN to produce signed overflow and signed-correct SLT; otherwise overflow is 0.
module serial_alu #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    serial_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, SLTFIX, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, res, res_shift;
    logic [2:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             carry, sign, zero_r, b_bit, add_bit, sum, cout, last, is_slt, set;
    always_comb begin
        state_nx  = state;
        b_bit     = b_sr[0] ^ op_r[2];
        add_bit   = a_sr[0] ^ b_bit ^ carry;
        cout      = (a_sr[0] & b_bit) | (carry & (a_sr[0] ^ b_bit));
        sum       = op_r[1] ? add_bit : (op_r[0] ? (a_sr[0] | b_bit) : (a_sr[0] & b_bit));
        res_shift = {sum, res[WIDTH-1:1]};
        last      = cnt == CW'(WIDTH - 1);
        is_slt    = op_r[1:0] == 2'b11;
        case (state)
            IDLE:    state_nx = bus.start ? SHIFT : IDLE;
            SHIFT:   state_nx = last ? (is_slt ? SLTFIX : DONE) : SHIFT;
            SLTFIX:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            op_r   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sign   <= 1'b0;
            res    <= '0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_sr  <= bus.a;
                    b_sr  <= bus.b;
                    op_r  <= bus.op;
                    carry <= bus.op[2];
                    cnt   <= '0;
                end
                SHIFT: begin
                    res   <= res_shift;
                    carry <= cout;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    cnt   <= last ? cnt : cnt + 1'b1;
                    if (last) begin
                        sign <= sum;
                        if (!is_slt) zero_r <= res_shift == '0;
                    end
                end
                SLTFIX: begin
                    res    <= {{(WIDTH-1){1'b0}}, set};
                    zero_r <= !set;
                end
                default: ;
            endcase
        end
    end
`ifdef SERIAL_ALU_OVF_EN
    // ovf_r is the raw MSB result; ovf_out only moves on entry to DONE
    logic ovf_r, ovf_out;
    assign set          = sign ^ ovf_r;
    assign bus.overflow = ovf_out;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r   <= 1'b0;
            ovf_out <= 1'b0;
        end else if (state == SHIFT && last) begin
            ovf_r <= carry ^ cout;
            if (!is_slt) ovf_out <= carry ^ cout;
        end else if (state == SLTFIX) begin
            ovf_out <= ovf_r;
        end
    end
`else
    assign set          = sign;
    assign bus.overflow = 1'b0;
`endif
    assign bus.busy   = state != IDLE;
    assign bus.done   = state == DONE;
    assign bus.result = res;
    assign bus.zero   = zero_r;
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: table vectors, randomized ops against an arithmetic model, start-hold and mid-op reset sequences.
module tb_serial_alu;
    localparam int WIDTH = 32;
`ifdef SERIAL_ALU_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif
    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    serial_alu_if #(.WIDTH(WIDTH)) bus ();
    serial_alu #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic o);
        logic [31:0] bb, s;
        logic v;
        bb = op[2] ? ~b : b;
        s  = a + bb + 32'(op[2]);
        v  = OVF && (a[31] == bb[31]) && (s[31] != a[31]);
        case (op[1:0])
            2'b00:   r = a & bb;
            2'b01:   r = a | bb;
            2'b10:   r = s;
            default: r = {31'd0, s[31] ^ v};
        endcase
        z = r == 32'd0;
        o = v;
    endfunction
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ez, input logic eo);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!bus.done && n < 60);
        chk({nm, " latency"}, 32'(n), (op[1:0] == 2'b11) ? 32'(WIDTH + 1) : 32'(WIDTH));
        chk({nm, " busy@done"}, 32'(bus.busy), 32'd1);
        chk({nm, " result"}, bus.result, er);
        chk({nm, " zero"}, 32'(bus.zero), 32'(ez));
        chk({nm, " overflow"}, 32'(bus.overflow), 32'(eo));
        @(negedge clk);
        chk({nm, " done pulse"}, 32'(bus.done), 32'd0);
        chk({nm, " busy after"}, 32'(bus.busy), 32'd0);
        chk({nm, " result held"}, bus.result, er);
    endtask
    task automatic drain();
        int n;
        n = 0;
        while (bus.busy && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("drain idle", 32'(bus.busy), 32'd0);
    endtask
    initial begin
        vec_t        vec[11];
        logic [31:0] r, x, y;
        logic [2:0]  op;
        logic        z, o, prev;
        int          last_i, pulses, wide, seen;
        vec[0]  = '{"add 5+7", 3'b010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
        vec[1]  = '{"sub 7-7", 3'b110, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0};
        vec[2]  = '{"and", 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
        vec[3]  = '{"slt -1<1", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0};
        vec[4]  = '{"slt 1<-1", 3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0};
        vec[5]  = '{"add ovf", 3'b010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, OVF};
        vec[6]  = '{"slt min<1", 3'b111, 32'h8000_0000, 32'd1, {31'd0, OVF}, !OVF, OVF};
        vec[7]  = '{"or", 3'b001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0};
        vec[8]  = '{"sub 0-1", 3'b110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vec[9]  = '{"sub min-1", 3'b110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, OVF};
        vec[10] = '{"sub 7-7 again", 3'b110, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0};
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        #3 rst_n  = 1'b0;
        #1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset zero", 32'(bus.zero), 32'd0);
        chk("reset overflow", 32'(bus.overflow), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++)
            run_op(vec[i].name, vec[i].op, vec[i].a, vec[i].b, vec[i].res, vec[i].zero, vec[i].ovf);
        // mid-SHIFT reset: zero is still held at 1 from the last vector, result partly shifted
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b010;
        bus.a     = 32'h0000_0155;
        bus.b     = 32'h0000_02AA;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort result", bus.result, 32'd0);
        chk("abort zero", 32'(bus.zero), 32'd0);
        chk("abort overflow", 32'(bus.overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("abort no done", 32'(seen), 32'd0);
        model(3'b010, 32'd100, 32'd23, r, z, o);
        run_op("post-reset add", 3'b010, 32'd100, 32'd23, r, z, o);
        // start held high: one accept per WIDTH+2 cycles, single-cycle done pulses
        x = $urandom;
        y = $urandom;
        model(3'b010, x, y, r, z, o);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b010;
        bus.a     = x;
        bus.b     = y;
        prev = 1'b0;
        last_i = -1;
        pulses = 0;
        wide = 0;
        for (int i = 0; i < 3 * (WIDTH + 2) + 4; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (prev) wide++;
                else begin
                    if (last_i >= 0) chk("hold spacing", 32'(i - last_i), 32'(WIDTH + 2));
                    last_i = i;
                    pulses++;
                    chk("hold result", bus.result, r);
                end
            end
            prev = bus.done;
        end
        bus.start = 1'b0;
        chk("hold pulses", 32'(pulses), 32'd3);
        chk("hold width", 32'(wide), 32'd0);
        drain();
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = pick();
            y  = pick();
            model(op, x, y, r, z, o);
            run_op($sformatf("rand%0d op%b", i, op), op, x, y, r, z, o);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
